link_tx_sched: RTL and testbench

Transmit scheduler for the 8b/10b serial link. It shares one encoder and PISO lane between two byte requesters using round-robin arbitration. It sends an alignment burst of K28.5 commas after reset and fills empty slots with K28.5 idles. It also generates the PISO load/shift timing and tracks running disparity from the encoded symbol. It sits between the requesters and the `encoder_8b10b`/`PISO` pair and drives their control inputs.

---
 rtl/link_tx_sched.sv | 72 +++++++
 tb/tb_link_tx_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/link_tx_sched.sv
// link_tx_sched: round-robin 8b/10b transmit scheduler with alignment burst, idle fill, PISO timing and disparity tracking
module link_tx_sched #(
  parameter int         ALIGN_COUNT = 4,
  parameter logic [7:0] COMMA       = 8'hBC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_k,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_k,
  output logic       req1_ready,
  output logic [7:0] enc_data,
  output logic       enc_k,
  output logic       enc_rd,
  input  logic [9:0] enc_symbol,
  output logic       mode,
  output logic [1:0] grant,
  output logic       link_up,
  output logic       disp_err
);
  typedef enum logic {ALIGN, RUN} state_t;
  state_t state, state_nx;
  logic [3:0] bit_cnt, ones;
  logic [$clog2(ALIGN_COUNT+1)-1:0] align_cnt;
  logic last_grant, load, sel, g0, g1, align_done;
  assign load = bit_cnt == 4'd0;
  assign sel = bit_cnt == 4'd9;
  assign mode = !load;
  assign ones = 4'($countones(enc_symbol));
  assign align_done = int'(align_cnt) + 1 == ALIGN_COUNT;
  // last_grant=1 means requester 1 went last, so requester 0 wins a tie
  assign g0 = state == RUN && req0_valid && (!req1_valid || last_grant);
  assign g1 = state == RUN && req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = sel && g0;
  assign req1_ready = sel && g1;
  always_comb state_nx = (state == ALIGN && load && align_done) ? RUN : state;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ALIGN;
      bit_cnt    <= '0;
      align_cnt  <= '0;
      enc_data   <= COMMA;
      enc_k      <= 1'b1;
      enc_rd     <= 1'b0;
      grant      <= 2'b00;
      link_up    <= 1'b0;
      disp_err   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state   <= state_nx;
      bit_cnt <= sel ? 4'd0 : bit_cnt + 4'd1;
      if (load) begin
        enc_rd <= ones == 4'd6 ? 1'b1 : ones == 4'd4 ? 1'b0 : enc_rd;
        if (ones < 4'd4 || ones > 4'd6) disp_err <= 1'b1;
        if (state == ALIGN) begin
          align_cnt <= align_cnt + 1'b1;
          if (align_done) link_up <= 1'b1;
        end
      end
      if (sel) begin
        enc_data <= g0 ? req0_data : g1 ? req1_data : COMMA;
        enc_k    <= g0 ? req0_k : g1 ? req1_k : 1'b1;
        grant    <= {g1, g0};
        if (g0 || g1) last_grant <= g1;
      end
    end
  end
endmodule

// File: tb/tb_link_tx_sched.sv
// tb_link_tx_sched: directed tables, corner sequences and a randomized reference-model run for link_tx_sched
module tb_link_tx_sched;
  localparam int AC = 4;
  logic clk = 1'b0, rst = 1'b0, bad = 1'b0;
  logic req0_valid = 1'b0, req0_k = 1'b0, req1_valid = 1'b0, req1_k = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, enc_k, enc_rd, mode, link_up, disp_err;
  logic [7:0] enc_data;
  logic [1:0] grant;
  logic [9:0] enc_symbol;
  int checks = 0, errors = 0;
  int m_c, m_loads;
  logic m_rd, m_k, m_link, m_err, m_last, acc0, acc1, s_r0, s_r1;
  logic [7:0] m_data;
  logic [1:0] m_grant;

  typedef struct {
    int c; logic rdy0; logic mode; logic link; logic [1:0] grant; logic [7:0] data; logic rd;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  link_tx_sched #(.ALIGN_COUNT(AC), .COMMA(8'hBC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_k(req0_k), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_k(req1_k), .req1_ready(req1_ready),
    .enc_data(enc_data), .enc_k(enc_k), .enc_rd(enc_rd), .enc_symbol(enc_symbol),
    .mode(mode), .grant(grant), .link_up(link_up), .disp_err(disp_err)
  );

  // Stand-in encoder: real K28.5 codes, data codes with a controlled ones-count
  function automatic logic [9:0] fake_enc(input logic [7:0] d, input logic k, input logic rd);
    if (k && d == 8'hBC) return rd ? 10'h305 : 10'h0FA;
    if (d[7] ^ k) return rd ? {d[3:0], ~d[3:0], 2'b00} : {d[3:0], ~d[3:0], 2'b11};
    return {d[4:0], ~d[4:0]};
  endfunction
  assign enc_symbol = bad ? 10'h3FF : fake_enc(enc_data, enc_k, enc_rd);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, m_c, act, exp);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_loads = 0; m_rd = 0; m_k = 1; m_data = 8'hBC; m_grant = 0;
    m_link = 0; m_err = 0; m_last = 1; acc0 = 0; acc1 = 0;
  endtask

  function automatic logic [1:0] m_win();
    if (!m_link || m_c % 10 != 9) return 2'b00;
    if (req0_valid && req1_valid) return m_last ? 2'b01 : 2'b10;
    return {req1_valid, req0_valid};
  endfunction

  task automatic model_edge();
    logic [1:0] w;
    int n;
    w = m_win();
    acc0 = w[0];
    acc1 = w[1];
    if (m_c % 10 == 0) begin
      n = $countones(bad ? 10'h3FF : fake_enc(m_data, m_k, m_rd));
      if (n == 6) m_rd = 1;
      else if (n == 4) m_rd = 0;
      else if (n != 5) m_err = 1;
      if (!m_link) begin
        m_loads++;
        if (m_loads == AC) m_link = 1;
      end
    end
    if (m_c % 10 == 9) begin
      m_data = w[0] ? req0_data : w[1] ? req1_data : 8'hBC;
      m_k = w[0] ? req0_k : w[1] ? req1_k : 1'b1;
      m_grant = w;
      if (w != 2'b00) m_last = w[1];
    end
    m_c++;
  endtask

  task automatic chk_regs();
    chk("mode", mode, m_c % 10 != 0);
    chk("enc_data", enc_data, m_data);
    chk("enc_k", enc_k, m_k);
    chk("enc_rd", enc_rd, m_rd);
    chk("grant", grant, m_grant);
    chk("link_up", link_up, m_link);
    chk("disp_err", disp_err, m_err);
  endtask

  task automatic cycle();
    logic [1:0] w;
    #1 w = m_win();
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    chk("req0_ready", s_r0, w[0]);
    chk("req1_ready", s_r1, w[1]);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_regs();
  endtask

  task automatic do_reset();
    rst = 0; bad = 0;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    model_reset();
    chk_regs();
    chk("rst req0_ready", req0_ready, 1'b0);
    chk("rst req1_ready", req1_ready, 1'b0);
    req0_valid = 0; req1_valid = 0;
    rst = 1;
  endtask

  task automatic run_table();
    for (int c = 0; c <= 50; c++) begin
      req0_valid = c <= 39; req0_data = 8'h4C; req0_k = 0;
      cycle();
      for (int j = 0; j < 10; j++)
        if (tbl[j].c == c) begin
          chk("tbl ready0", s_r0, tbl[j].rdy0);
          chk("tbl mode", mode, tbl[j].mode);
          chk("tbl link_up", link_up, tbl[j].link);
          chk("tbl grant", grant, tbl[j].grant);
          chk("tbl enc_data", enc_data, tbl[j].data);
          chk("tbl enc_rd", enc_rd, tbl[j].rd);
        end
    end
  endtask

  initial begin
    tbl = '{
      '{0,  0, 1, 0, 2'b00, 8'hBC, 1}, '{9,  0, 0, 0, 2'b00, 8'hBC, 1},
      '{10, 0, 1, 0, 2'b00, 8'hBC, 0}, '{20, 0, 1, 0, 2'b00, 8'hBC, 1},
      '{30, 0, 1, 1, 2'b00, 8'hBC, 0}, '{38, 0, 1, 1, 2'b00, 8'hBC, 0},
      '{39, 1, 0, 1, 2'b01, 8'h4C, 0}, '{40, 0, 1, 1, 2'b01, 8'h4C, 0},
      '{49, 0, 0, 1, 2'b00, 8'hBC, 0}, '{50, 0, 1, 1, 2'b00, 8'hBC, 1}};
    do_reset();
    run_table();
    // both requesters continuously valid
    do_reset();
    req0_valid = 1; req0_data = 8'h11; req0_k = 0;
    req1_valid = 1; req1_data = 8'h22; req1_k = 0;
    for (int c = 0; c <= 70; c++) begin
      cycle();
      chk("rr ready0", s_r0, c == 39 || c == 59);
      chk("rr ready1", s_r1, c == 49 || c == 69);
      if (c % 10 == 9 && c >= 39) chk("rr grant", grant, (c == 39 || c == 59) ? 2'b01 : 2'b10);
    end
    // mid-symbol request arrival, no duplicate acceptance
    do_reset();
    req1_data = 8'h5A; req1_k = 0;
    for (int c = 0; c <= 60; c++) begin
      req1_valid = c >= 43 && c <= 49;
      cycle();
      if (c >= 40) chk("late ready1", s_r1, c == 49);
    end
    // reset mid-symbol with a data grant in flight
    do_reset();
    for (int c = 0; c <= 44; c++) begin
      req0_valid = c <= 39; req0_data = 8'h4C; req0_k = 0;
      cycle();
    end
    #2 rst = 0;
    #1 chk("midrst mode", mode, 1'b0);
    chk("midrst link_up", link_up, 1'b0);
    chk("midrst grant", grant, 2'b00);
    chk("midrst enc_data", enc_data, 8'hBC);
    do_reset();
    run_table();
    // corrupted symbol at a load edge
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      bad = c == 10;
      cycle();
      if (c == 10) chk("bad enc_rd", enc_rd, 1'b1);
      if (c >= 10) chk("bad disp_err", disp_err, 1'b1);
    end
    bad = 0;
    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (acc0 || !req0_valid) begin
        req0_valid = $urandom_range(0, 2) != 0;
        req0_data = 8'($urandom);
        req0_k = $urandom_range(0, 3) == 0;
      end
      if (acc1 || !req1_valid) begin
        req1_valid = $urandom_range(0, 2) != 0;
        req1_data = 8'($urandom);
        req1_k = $urandom_range(0, 3) == 0;
      end
      bad = $urandom_range(0, 999) == 0;
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
